// File: rtl/p_emap_gather.sv
// p_emap_gather: banked dense-vector gather unit.
// Three-stage decode/read/select pipeline with valid/ready output.
module p_emap_gather #(
  parameter int    NO_OF_LANES   = 8,
  parameter int    ELEMENT_WIDTH = 32,
  parameter int    NO_OF_UNITS   = 8,
  parameter int    MEMORY_HEIGHT = 1024,
  parameter int    ADDRESS_WIDTH = $clog2(MEMORY_HEIGHT),
  parameter int    COL_WIDTH     = 24,
  parameter int    MAX_CHUNKS    = 4,
  parameter int    CNT_WIDTH     = $clog2(MAX_CHUNKS+1),
  parameter string INIT_FILE     = ""
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [MAX_CHUNKS*NO_OF_LANES*COL_WIDTH-1:0] col_nos,
  input  logic [CNT_WIDTH-1:0]                      no_of_multiples,
  output logic                                      busy,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [NO_OF_LANES*ELEMENT_WIDTH-1:0]      output_row,
  output logic [CNT_WIDTH-1:0]                      out_chunk,
  output logic                                      out_last,
  output logic                                      range_err,
  input  logic                                      write_enable,
  input  logic [ADDRESS_WIDTH-1:0]                  write_address,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]      input_data
);
  localparam int SHIFT   = $clog2(NO_OF_UNITS);
  localparam int SEL_W   = (SHIFT > 0) ? SHIFT : 1;
  localparam int CHUNK_W = NO_OF_LANES*COL_WIDTH;
  localparam int MEM_W   = NO_OF_UNITS*ELEMENT_WIDTH;
  localparam int ROW_W   = NO_OF_LANES*ELEMENT_WIDTH;
  localparam logic [COL_WIDTH-1:0] INVALID  = '1;
  localparam logic [COL_WIDTH-1:0] SEL_MASK = COL_WIDTH'(NO_OF_UNITS-1);
  localparam logic [COL_WIDTH-1:0] HEIGHT   = COL_WIDTH'(MEMORY_HEIGHT);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(MAX_CHUNKS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nx;

  logic [MEM_W-1:0] mem [MEMORY_HEIGHT];

  logic [MAX_CHUNKS*CHUNK_W-1:0] col_q;
  logic [CNT_WIDTH-1:0]          num_q;
  logic [CNT_WIDTH-1:0]          cnt_q;
  logic [CNT_WIDTH-1:0]          num_in;
  logic [CHUNK_W-1:0]            cur;

  logic stall, adv, accept;
  logic load, issue, issue_last;

  logic [NO_OF_LANES-1:0]   oor;
  logic [NO_OF_LANES-1:0]   zero_nx;
  logic [ADDRESS_WIDTH-1:0] word_nx [NO_OF_LANES];
  logic [SEL_W-1:0]         sel_nx  [NO_OF_LANES];

  logic                     s1_valid, s1_last;
  logic [CNT_WIDTH-1:0]     s1_chunk;
  logic [NO_OF_LANES-1:0]   s1_zero;
  logic [ADDRESS_WIDTH-1:0] s1_word [NO_OF_LANES];
  logic [SEL_W-1:0]         s1_sel  [NO_OF_LANES];

  logic                     s2_valid, s2_last;
  logic [CNT_WIDTH-1:0]     s2_chunk;
  logic [NO_OF_LANES-1:0]   s2_zero;
  logic [MEM_W-1:0]         s2_data [NO_OF_LANES];
  logic [SEL_W-1:0]         s2_sel  [NO_OF_LANES];

  logic [ROW_W-1:0] row_nx;

  assign busy   = (state != IDLE);
  assign stall  = out_valid & ~out_ready;
  assign adv    = ~stall;
  assign accept = out_valid & out_ready;
  assign num_in = (no_of_multiples > MAX_CNT) ? MAX_CNT : no_of_multiples;
  assign issue_last = (cnt_q == num_q - CNT_WIDTH'(1));

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    issue    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && no_of_multiples != '0) begin
          load     = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (adv) begin
          issue = 1'b1;
          if (issue_last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && out_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cur = '0;
    for (int c = 0; c < MAX_CHUNKS; c++)
      if (cnt_q == CNT_WIDTH'(c))
        cur = col_q[(MAX_CHUNKS-1-c)*CHUNK_W +: CHUNK_W];
  end

  for (genvar k = 0; k < NO_OF_LANES; k++) begin : g_dec
    logic [COL_WIDTH-1:0] idx;
    logic [COL_WIDTH-1:0] wfull;
    logic                 inv;
    assign idx   = cur[(NO_OF_LANES-1-k)*COL_WIDTH +: COL_WIDTH];
    assign wfull = idx >> SHIFT;
    assign inv   = (idx == INVALID);
    assign oor[k]     = !inv && (wfull >= HEIGHT);
    assign zero_nx[k] = inv || oor[k];
    assign word_nx[k] = zero_nx[k] ? '0 : wfull[ADDRESS_WIDTH-1:0];
    assign sel_nx[k]  = SEL_W'(idx & SEL_MASK);
  end

  for (genvar k = 0; k < NO_OF_LANES; k++) begin : g_sel
    logic [ELEMENT_WIDTH-1:0] e;
    always_comb begin
      e = '0;
      for (int u = 0; u < NO_OF_UNITS; u++)
        if (s2_sel[k] == SEL_W'(u))
          e = s2_data[k][(NO_OF_UNITS-1-u)*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      if (s2_zero[k]) e = '0;
    end
    assign row_nx[(NO_OF_LANES-1-k)*ELEMENT_WIDTH +: ELEMENT_WIDTH] = e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col_q     <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      range_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        col_q <= col_nos;
        num_q <= num_in;
        cnt_q <= '0;
      end else if (issue) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (issue && |oor) range_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_chunk   <= '0;
      s1_zero    <= '0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      s2_chunk   <= '0;
      s2_zero    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_chunk  <= '0;
      output_row <= '0;
    end else if (adv) begin
      s1_valid   <= issue;
      s1_last    <= issue_last;
      s1_chunk   <= cnt_q;
      s1_zero    <= zero_nx;
      s2_valid   <= s1_valid;
      s2_last    <= s1_last;
      s2_chunk   <= s1_chunk;
      s2_zero    <= s1_zero;
      out_valid  <= s2_valid;
      out_last   <= s2_valid & s2_last;
      out_chunk  <= s2_valid ? s2_chunk : '0;
      output_row <= s2_valid ? row_nx : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (write_enable) mem[write_address] <= input_data;
    if (adv) begin
      for (int k = 0; k < NO_OF_LANES; k++) begin
        s1_word[k] <= word_nx[k];
        s1_sel[k]  <= sel_nx[k];
        s2_data[k] <= mem[s1_word[k]];
        s2_sel[k]  <= s1_sel[k];
      end
    end
  end

endmodule
